div_unit: RTL and testbench
===========================

Name: div_unit

Overview:
- Iterative radix-2 integer divider for the CPU execute stage, implementing RV32M DIV/DIVU/REM/REMU.
- Takes operands as read from the register file.
- Drives a write port of the register file (write_en/write_addr/write_data).
- Provides busy/busy_rd so decode can stall instructions that depend on the destination.

Parameters:
WIDTH, 32, operand/result width in bits
ADDR_W, 5, register address width

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous, active-high; clears all state immediately
in_valid  input  1  operation request
in_ready  output  1  unit can accept a request (high only in IDLE)
op  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU
rs1_data  input  WIDTH  dividend
rs2_data  input  WIDTH  divisor
rd_addr  input  ADDR_W  destination register
flush  input  1  abort in-flight operation, no writeback
busy  output  1  operation in flight (state != IDLE)
busy_rd  output  ADDR_W  rd of in-flight op; 0 when idle
wb_en  output  1  one-cycle register-file write strobe
wb_addr  output  ADDR_W  write address
wb_data  output  WIDTH  result

Behaviour:
- Reset values: state=IDLE, in_ready=1, busy=0, busy_rd=0, wb_en=0, wb_addr=0, wb_data=0, all internal registers 0.
- Accept: handshake completes on an edge N where in_valid && in_ready. At that edge the unit latches op, rd_addr, the operand magnitudes and the result signs.
  - Signed ops: quotient sign = sign(a) XOR sign(b); remainder sign = sign(a).
- Special cases, detected at accept, skip CALC (state goes to FIN, result preloaded):
  - Divide by zero: quotient = all ones (0xFFFFFFFF), remainder = dividend.
  - Signed overflow (DIV/REM with a=0x80000000, b=0xFFFFFFFF): quotient = 0x80000000, remainder = 0.
- States: IDLE -> CALC (normal) or FIN (special); CALC -> FIN after WIDTH steps; FIN -> IDLE.
- CALC: one restoring step per edge, for edges N+1 through N+WIDTH.
  - Each step shifts {rem, quo} left by 1.
  - If rem >= divisor magnitude, subtract and set the quotient LSB.
  - Step counter is $clog2(WIDTH) bits, wraps cleanly, and at the last step moves the state to FIN.
- FIN: on the following edge, register wb_data (sign-corrected quotient or remainder per op), wb_addr=latched rd, wb_en=1 if rd != 0 (x0 is never written), and move to IDLE.
- wb_en is registered and high for exactly one cycle. It is cleared on the next edge unless a new FIN completes.
- Latency from the accept edge to the wb_en-high cycle:
  - Normal case: WIDTH+1 edges (33 for WIDTH=32).
  - Special case: 1 edge.
- No backpressure on the writeback side; the register file always accepts.
- in_ready = (state==IDLE). A request may be accepted in the same cycle that wb_en is high (back-to-back).
- busy = (state != IDLE); busy_rd = latched rd while busy, else 0.
- flush: sampled on clock edges; if asserted on an edge, the next state is IDLE.
  - No wb_en results from the aborted op, even if it was in FIN.
  - flush takes priority over accept on the same edge: no new request is accepted.
  - flush with no op in flight has no effect.
- reset asserted mid-operation: all outputs immediately return to reset values and the pending result is discarded. After deassertion, in_ready=1.
- Arithmetic:
  - Magnitude conversion is two's-complement negate when signed and negative. 0x80000000 maps to unsigned 0x80000000, which is correct.
  - Unsigned ops use the raw operands.
  - All internal datapaths are WIDTH bits, except the remainder compare/subtract, which is WIDTH+1 bits.
- Inputs other than in_valid/flush are don't-care when no handshake occurs.

Test Plan:
- DIVU 100/7, rd=5 -> wb_en high exactly 33 edges after accept, wb_addr=5, wb_data=14; REMU same operands -> wb_data=2.
- DIV -7/2 (0xFFFFFFF9, 2), rd=3 -> wb_data=0xFFFFFFFD (-3); REM -> 0xFFFFFFFF (-1); DIV 7/-2 -> 0xFFFFFFFD; REM 7/-2 -> 1.
- Divide by zero: DIV 42/0 -> wb_data=0xFFFFFFFF one edge after accept; REMU 42/0 -> 42. Overflow DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0.
- Handshake/hazard: in_valid held high continuously -> second op accepted on the wb_en cycle. busy_rd equals rd during flight. rd=0 -> busy for 33 cycles, wb_en never asserts.
- flush at CALC step 10 -> no wb_en ever, in_ready=1 next cycle; flush coincident with in_valid in IDLE -> request not accepted.
- reset asserted asynchronously at step 20 -> outputs zero before the next edge, no writeback; a new DIVU 9/3 after release -> wb_data=3.

Source files
------------

// File: rtl/div_unit.sv
// rtl/div_unit.sv - iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU
module div_unit #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        op,
    input  logic [WIDTH-1:0]  rs1_data,
    input  logic [WIDTH-1:0]  rs2_data,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              flush,
    output logic              busy,
    output logic [ADDR_W-1:0] busy_rd,
    output logic              wb_en,
    output logic [ADDR_W-1:0] wb_addr,
    output logic [WIDTH-1:0]  wb_data
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MOST_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t state, state_next;

    logic [1:0]        op_r;
    logic [ADDR_W-1:0] rd_r;
    logic [WIDTH-1:0]  quo;
    logic [WIDTH-1:0]  rem;
    logic [WIDTH-1:0]  div_mag;
    logic              q_neg;
    logic              r_neg;
    logic [CNT_W-1:0]  cnt;

    logic              accept;
    logic              signed_op;
    logic              a_neg;
    logic              b_neg;
    logic [WIDTH-1:0]  a_mag;
    logic [WIDTH-1:0]  b_mag;
    logic              div_zero;
    logic              overflow;
    logic [WIDTH:0]    rem_sh;
    logic [WIDTH:0]    rem_diff;
    logic              rem_ge;
    logic [WIDTH-1:0]  rem_next;
    logic [WIDTH-1:0]  res_mag;
    logic              res_neg;
    logic [WIDTH-1:0]  result;

    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);
    assign busy_rd  = busy ? rd_r : '0;

    // flush wins over a same-edge request
    assign accept    = in_valid && in_ready && !flush;
    assign signed_op = !op[0];
    assign a_neg     = signed_op && rs1_data[WIDTH-1];
    assign b_neg     = signed_op && rs2_data[WIDTH-1];
    assign a_mag     = a_neg ? -rs1_data : rs1_data;
    assign b_mag     = b_neg ? -rs2_data : rs2_data;
    assign div_zero  = (rs2_data == '0);
    assign overflow  = signed_op && (rs1_data == MOST_NEG) && (rs2_data == '1);

    // one restoring step: shift {rem, quo} left, subtract when the divisor fits
    assign rem_sh   = {rem, quo[WIDTH-1]};
    assign rem_diff = rem_sh - {1'b0, div_mag};
    assign rem_ge   = (rem_sh >= {1'b0, div_mag});
    assign rem_next = rem_ge ? rem_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];

    // pick quotient or remainder and restore its sign
    assign res_mag = op_r[1] ? rem : quo;
    assign res_neg = op_r[1] ? r_neg : q_neg;
    assign result  = res_neg ? -res_mag : res_mag;

    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // next-state logic; special cases bypass the iteration
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = (div_zero || overflow) ? FIN : CALC;
            CALC: if (cnt == LAST_STEP) state_next = FIN;
            FIN:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (flush) begin
            state_next = IDLE;
        end
    end

    // datapath: operand capture, iteration and registered writeback
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_r    <= '0;
            rd_r    <= '0;
            quo     <= '0;
            rem     <= '0;
            div_mag <= '0;
            q_neg   <= 1'b0;
            r_neg   <= 1'b0;
            cnt     <= '0;
            wb_en   <= 1'b0;
            wb_addr <= '0;
            wb_data <= '0;
        end else begin
            wb_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_r <= op;
                        rd_r <= rd_addr;
                        cnt  <= '0;
                        if (div_zero) begin
                            quo     <= '1;
                            rem     <= rs1_data;
                            div_mag <= '0;
                            q_neg   <= 1'b0;
                            r_neg   <= 1'b0;
                        end else if (overflow) begin
                            quo     <= MOST_NEG;
                            rem     <= '0;
                            div_mag <= b_mag;
                            q_neg   <= 1'b0;
                            r_neg   <= 1'b0;
                        end else begin
                            quo     <= a_mag;
                            rem     <= '0;
                            div_mag <= b_mag;
                            q_neg   <= a_neg ^ b_neg;
                            r_neg   <= a_neg;
                        end
                    end
                end
                CALC: begin
                    quo <= {quo[WIDTH-2:0], rem_ge};
                    rem <= rem_next;
                    cnt <= cnt + CNT_W'(1);
                end
                FIN: begin
                    if (!flush) begin
                        wb_en   <= (rd_r != '0);
                        wb_addr <= rd_r;
                        wb_data <= result;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - scoreboard bench for div_unit against an arithmetic reference
module tb_div_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  op;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [4:0]  rd_addr;
    logic        flush;
    logic        busy;
    logic [4:0]  busy_rd;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;

    div_unit #(.WIDTH(32), .ADDR_W(5)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .rs1_data(rs1_data), .rs2_data(rs2_data), .rd_addr(rd_addr),
        .flush(flush), .busy(busy), .busy_rd(busy_rd), .wb_en(wb_en),
        .wb_addr(wb_addr), .wb_data(wb_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
        int unsigned due;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;
    int unsigned cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at cycle %0d", name, act, req, cyc);
        end
    endtask

    // RV32M results from plain integer arithmetic
    function automatic logic [31:0] ref_result(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        int sa, sb_v;
        sa = a;
        sb_v = b;
        if (b == 32'd0) return o[1] ? a : 32'hFFFF_FFFF;
        if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return o[1] ? 32'd0 : 32'h8000_0000;
        case (o)
            2'b00: return 32'(sa / sb_v);
            2'b01: return a / b;
            2'b10: return 32'(sa % sb_v);
            default: return a % b;
        endcase
    endfunction

    function automatic bit is_special(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        return (b == 32'd0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    // expectation for a request accepted on the coming edge
    task automatic push_exp(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        exp_t e;
        if (rd != 5'd0) begin
            e.addr = rd;
            e.data = ref_result(o, a, b);
            e.due  = cyc + 1 + (is_special(o, a, b) ? 1 : 33);
            sb.push_back(e);
        end
    endtask

    // monitor: every writeback must match the oldest expectation, on time
    always @(negedge clk) begin
        exp_t e;
        if (!reset && wb_en) begin
            if (sb.size() == 0) begin
                chk("unexpected_wb", {59'd0, wb_addr}, 64'hFFFF);
            end else begin
                e = sb.pop_front();
                chk("wb_addr", {59'd0, wb_addr}, {59'd0, e.addr});
                chk("wb_data", {32'd0, wb_data}, {32'd0, e.data});
                chk("wb_latency", {32'd0, cyc}, {32'd0, e.due});
            end
        end
    end

    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        int n = 0;
        @(negedge clk);
        in_valid = 1'b1; op = o; rs1_data = a; rs2_data = b; rd_addr = rd;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 64'd0, 64'd1);
            in_valid = 1'b0;
        end else begin
            push_exp(o, a, b, rd);
            @(negedge clk);
            in_valid = 1'b0;
            chk("busy_in_flight", {63'd0, busy}, 64'd1);
            chk("busy_rd", {59'd0, busy_rd}, {59'd0, rd});
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || sb.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (busy || sb.size() != 0) chk("idle_timeout", 64'd0, 64'd1);
        @(negedge clk);
    endtask

    initial begin
        int n;
        reset = 1'b1; in_valid = 1'b0; flush = 1'b0;
        op = 2'b00; rs1_data = '0; rs2_data = '0; rd_addr = '0;
        #12;
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_busy_rd", {59'd0, busy_rd}, 64'd0);
        chk("rst_wb_en", {63'd0, wb_en}, 64'd0);
        chk("rst_wb_addr", {59'd0, wb_addr}, 64'd0);
        chk("rst_wb_data", {32'd0, wb_data}, 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // directed arithmetic cases, including the special paths
        issue(2'b01, 32'd100, 32'd7, 5'd5);          wait_idle();
        issue(2'b11, 32'd100, 32'd7, 5'd5);          wait_idle();
        issue(2'b00, 32'hFFFF_FFF9, 32'd2, 5'd3);    wait_idle();
        issue(2'b10, 32'hFFFF_FFF9, 32'd2, 5'd3);    wait_idle();
        issue(2'b00, 32'd7, 32'hFFFF_FFFE, 5'd3);    wait_idle();
        issue(2'b10, 32'd7, 32'hFFFF_FFFE, 5'd3);    wait_idle();
        issue(2'b00, 32'd42, 32'd0, 5'd8);           wait_idle();
        issue(2'b11, 32'd42, 32'd0, 5'd8);           wait_idle();
        issue(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9); wait_idle();
        issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9); wait_idle();
        issue(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9); wait_idle();

        // rd=0: full-length busy, never a writeback
        issue(2'b01, 32'd1000, 32'd3, 5'd0);
        n = 1;
        while (busy && n < 100) begin
            @(negedge clk);
            if (busy) n++;
        end
        chk("rd0_busy_cycles", 64'(n), 64'd33);
        wait_idle();

        // back-to-back with in_valid held: second accept lands on the wb_en cycle
        @(negedge clk);
        in_valid = 1'b1; op = 2'b01; rs1_data = 32'd55; rs2_data = 32'd5; rd_addr = 5'd10;
        push_exp(2'b01, 32'd55, 32'd5, 5'd10);
        @(negedge clk);
        op = 2'b11; rs1_data = 32'd58; rs2_data = 32'd5; rd_addr = 5'd11;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("b2b_accept_on_wb", {62'd0, in_ready, wb_en}, 64'd3);
        push_exp(2'b11, 32'd58, 32'd5, 5'd11);
        @(negedge clk);
        in_valid = 1'b0;
        wait_idle();

        // flush during CALC step 10
        issue(2'b01, 32'd12345, 32'd17, 5'd7);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        void'(sb.pop_back());
        chk("flush_in_ready", {63'd0, in_ready}, 64'd1);
        chk("flush_busy", {63'd0, busy}, 64'd0);
        repeat (40) @(negedge clk);

        // flush while in FIN
        issue(2'b00, 32'd5, 32'd0, 5'd12);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        void'(sb.pop_back());
        chk("flush_fin_busy", {63'd0, busy}, 64'd0);
        repeat (3) @(negedge clk);

        // flush with a request in IDLE: nothing is accepted
        in_valid = 1'b1; flush = 1'b1; op = 2'b01; rs1_data = 32'd9; rs2_data = 32'd3; rd_addr = 5'd13;
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0;
        chk("flush_idle_no_accept", {62'd0, busy, in_ready}, 64'd1);
        repeat (40) @(negedge clk);

        // asynchronous reset mid-calculation
        issue(2'b01, 32'd999, 32'd4, 5'd4);
        repeat (18) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("arst_busy", {63'd0, busy}, 64'd0);
        chk("arst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("arst_outputs", {wb_en, wb_addr, wb_data, busy_rd}, 64'd0);
        sb.delete();
        @(negedge clk);
        reset = 1'b0;
        issue(2'b01, 32'd9, 32'd3, 5'd6);
        wait_idle();

        // randomized operations
        for (int i = 0; i < 60; i++) begin
            logic [1:0]  o;
            logic [31:0] a, b;
            logic [4:0]  rd;
            o  = 2'($urandom_range(0, 3));
            a  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom();
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: b = 32'hFFFF_FFFF;
                2: b = 32'($urandom_range(1, 9));
                default: b = $urandom();
            endcase
            if ($urandom_range(0, 9) == 0) a = 32'h8000_0000;
            rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            issue(o, a, b, rd);
            if ($urandom_range(0, 1) == 1) wait_idle();
        end
        wait_idle();

        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
